// File: rtl/ahb5_mgr_arbiter.sv
// Round-robin arbiter sharing one AHB5 subordinate port between NUM_MGR managers.
// Address phase is muxed from the registered grant; data phase follows the pipelined owner.
module ahb5_mgr_arbiter #(
    parameter int NUM_MGR    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int MW         = (NUM_MGR > 1) ? $clog2(NUM_MGR) : 1
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic [NUM_MGR-1:0]               m_req,
    input  logic [NUM_MGR*ADDR_WIDTH-1:0]    m_haddr,
    input  logic [NUM_MGR*2-1:0]             m_htrans,
    input  logic [NUM_MGR-1:0]               m_hwrite,
    input  logic [NUM_MGR*3-1:0]             m_hsize,
    input  logic [NUM_MGR*3-1:0]             m_hburst,
    input  logic [NUM_MGR*DATA_WIDTH-1:0]    m_hwdata,
    input  logic [NUM_MGR*STRB_WIDTH-1:0]    m_hwstrb,
    input  logic                             HREADY,
    output logic [NUM_MGR-1:0]               m_grant,
    output logic [ADDR_WIDTH-1:0]            HADDR,
    output logic                             HWRITE,
    output logic [2:0]                       HSIZE,
    output logic [2:0]                       HBURST,
    output logic [1:0]                       HTRANS,
    output logic [DATA_WIDTH-1:0]            HWDATA,
    output logic [STRB_WIDTH-1:0]            HWSTRB,
    output logic [MW-1:0]                    hmaster_data,
    output logic                             data_valid
);

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [2:0] BU_INCR   = 3'd1;

    logic [NUM_MGR-1:0] addr_owner_q, addr_owner_d;
    logic [MW-1:0]      data_owner_q, data_owner_d;
    logic               data_valid_q, data_valid_d;
    logic [4:0]         beats_left_q, beats_left_d;
    logic [MW-1:0]      rr_last_q, rr_last_d;

    logic [MW-1:0]      owner_idx;
    logic               owner_vld;
    logic               own_req;
    logic [1:0]         own_htrans;
    logic [2:0]         own_hburst;
    logic               accept;
    logic               burst_done;
    logic               arb_point;
    logic               win_vld;
    logic [MW-1:0]      win_idx;

    function automatic logic [4:0] burst_last(input logic [2:0] hburst);
        case (hburst)
            3'd2, 3'd3: burst_last = 5'd3;
            3'd4, 3'd5: burst_last = 5'd7;
            3'd6, 3'd7: burst_last = 5'd15;
            default:    burst_last = 5'd0;
        endcase
    endfunction

    // Address-phase mux; all zero (IDLE) when nobody holds the grant.
    always_comb begin
        owner_idx  = '0;
        own_req    = 1'b0;
        own_htrans = TR_IDLE;
        own_hburst = 3'd0;
        HADDR      = '0;
        HWRITE     = 1'b0;
        HSIZE      = 3'd0;
        for (int i = 0; i < NUM_MGR; i++) begin
            if (addr_owner_q[i]) begin
                owner_idx  = MW'(i);
                own_req    = m_req[i];
                own_htrans = m_htrans[i*2 +: 2];
                own_hburst = m_hburst[i*3 +: 3];
                HADDR      = m_haddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                HWRITE     = m_hwrite[i];
                HSIZE      = m_hsize[i*3 +: 3];
            end
        end
    end

    assign owner_vld = |addr_owner_q;
    assign HTRANS    = own_htrans;
    assign HBURST    = own_hburst;

    always_comb begin
        HWDATA = '0;
        HWSTRB = '0;
        for (int i = 0; i < NUM_MGR; i++) begin
            if (data_valid_q && (data_owner_q == MW'(i))) begin
                HWDATA = m_hwdata[i*DATA_WIDTH +: DATA_WIDTH];
                HWSTRB = m_hwstrb[i*STRB_WIDTH +: STRB_WIDTH];
            end
        end
    end

    // Beat accounting and arbitration-point detection.
    always_comb begin
        accept       = HREADY && owner_vld && own_htrans[1];
        beats_left_d = beats_left_q;
        if (accept) begin
            if (own_htrans == TR_NONSEQ) beats_left_d = burst_last(own_hburst);
            else                         beats_left_d = beats_left_q - 5'd1;
        end
        burst_done = accept && (own_hburst != BU_INCR) && (beats_left_d == 5'd0);
        arb_point  = HREADY && (!owner_vld || (own_htrans == TR_IDLE) || burst_done ||
                                ((own_hburst == BU_INCR) && !own_req));
    end

    // Descending scan so the nearest requester after rr_last overwrites the rest.
    always_comb begin
        int c;
        c       = 0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = NUM_MGR; k >= 1; k--) begin
            c = (int'(rr_last_q) + k) % NUM_MGR;
            if (m_req[MW'(c)]) begin
                win_vld = 1'b1;
                win_idx = MW'(c);
            end
        end
    end

    always_comb begin
        addr_owner_d = addr_owner_q;
        rr_last_d    = rr_last_q;
        data_owner_d = data_owner_q;
        data_valid_d = data_valid_q;
        if (arb_point) begin
            for (int i = 0; i < NUM_MGR; i++) begin
                addr_owner_d[i] = win_vld && (win_idx == MW'(i));
            end
            if (win_vld) rr_last_d = win_idx;
        end
        if (HREADY) begin
            data_owner_d = owner_idx;
            data_valid_d = accept;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_owner_q <= '0;
            data_owner_q <= '0;
            data_valid_q <= 1'b0;
            beats_left_q <= 5'd0;
            rr_last_q    <= MW'(NUM_MGR - 1);
        end else begin
            addr_owner_q <= addr_owner_d;
            data_owner_q <= data_owner_d;
            data_valid_q <= data_valid_d;
            beats_left_q <= beats_left_d;
            rr_last_q    <= rr_last_d;
        end
    end

    assign m_grant      = addr_owner_q;
    assign hmaster_data = data_owner_q;
    assign data_valid   = data_valid_q;

endmodule

// File: tb/tb_ahb5_mgr_arbiter.sv
// Directed bench for ahb5_mgr_arbiter: a transfer-level model checked every cycle
// plus literal expectations for the scenario milestones.
module tb_ahb5_mgr_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic HCLK;
    logic HRESET;
    logic HREADY;

    logic [NM-1:0]    m_req;
    logic [NM*AW-1:0] m_haddr;
    logic [NM*2-1:0]  m_htrans;
    logic [NM-1:0]    m_hwrite;
    logic [NM*3-1:0]  m_hsize;
    logic [NM*3-1:0]  m_hburst;
    logic [NM*DW-1:0] m_hwdata;
    logic [NM*SW-1:0] m_hwstrb;

    logic [NM-1:0] m_grant;
    logic [AW-1:0] HADDR;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [2:0]    HBURST;
    logic [1:0]    HTRANS;
    logic [DW-1:0] HWDATA;
    logic [SW-1:0] HWSTRB;
    logic [0:0]    hmaster_data;
    logic          data_valid;

    logic          a_req   [NM];
    logic [1:0]    a_trans [NM];
    logic [AW-1:0] a_addr  [NM];
    logic          a_write [NM];
    logic [2:0]    a_size  [NM];
    logic [2:0]    a_burst [NM];
    logic [DW-1:0] a_wd    [NM];
    logic [SW-1:0] a_strb  [NM];

    for (genvar g = 0; g < NM; g++) begin : g_pack
        assign m_req[g]               = a_req[g];
        assign m_haddr[g*AW +: AW]    = a_addr[g];
        assign m_htrans[g*2 +: 2]     = a_trans[g];
        assign m_hwrite[g]            = a_write[g];
        assign m_hsize[g*3 +: 3]      = a_size[g];
        assign m_hburst[g*3 +: 3]     = a_burst[g];
        assign m_hwdata[g*DW +: DW]   = a_wd[g];
        assign m_hwstrb[g*SW +: SW]   = a_strb[g];
    end

    ahb5_mgr_arbiter #(.NUM_MGR(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .m_req(m_req), .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite),
        .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hwdata(m_hwdata), .m_hwstrb(m_hwstrb),
        .HREADY(HREADY), .m_grant(m_grant),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS),
        .HWDATA(HWDATA), .HWSTRB(HWSTRB), .hmaster_data(hmaster_data), .data_valid(data_valid)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transfer-level model: owner as an index (-1 = none), remaining beats in the burst.
    int mo = -1, mrem = 0, mrr = NM - 1, mdo = 0;
    bit mdv = 0, live = 0;

    function automatic int burst_beats(input int b);
        case (b)
            0, 1:    return 1;
            2, 3:    return 4;
            4, 5:    return 8;
            default: return 16;
        endcase
    endfunction

    always @(posedge HCLK) begin
        int t, b;
        bit acc, arb;
        if (HRESET) begin
            mo = -1; mrem = 0; mrr = NM - 1; mdo = 0; mdv = 0; live = 1;
        end else if (HREADY) begin
            t   = (mo >= 0) ? int'(a_trans[mo]) : 0;
            b   = (mo >= 0) ? int'(a_burst[mo]) : 0;
            acc = (mo >= 0) && (t == 2 || t == 3);
            if (acc) mrem = (t == 2) ? burst_beats(b) - 1 : ((mrem - 1) & 31);
            arb = (mo < 0) || (t == 0) || (acc && b != 1 && mrem == 0) ||
                  (mo >= 0 && b == 1 && !a_req[mo]);
            mdo = (mo < 0) ? 0 : mo;
            mdv = acc;
            if (arb) begin
                mo = -1;
                for (int k = 1; k <= NM; k++) begin
                    if (mo < 0 && a_req[(mrr + k) % NM]) mo = (mrr + k) % NM;
                end
                if (mo >= 0) mrr = mo;
            end
        end
    end

    always @(negedge HCLK) begin
        if (live) begin
            chk("mdl m_grant", 64'(m_grant), (mo < 0) ? 64'd0 : (64'd1 << mo));
            chk("mdl HTRANS",  64'(HTRANS),  (mo < 0) ? 64'd0 : 64'(a_trans[mo]));
            chk("mdl HADDR",   64'(HADDR),   (mo < 0) ? 64'd0 : 64'(a_addr[mo]));
            chk("mdl HWRITE",  64'(HWRITE),  (mo < 0) ? 64'd0 : 64'(a_write[mo]));
            chk("mdl HSIZE",   64'(HSIZE),   (mo < 0) ? 64'd0 : 64'(a_size[mo]));
            chk("mdl HBURST",  64'(HBURST),  (mo < 0) ? 64'd0 : 64'(a_burst[mo]));
            chk("mdl HWDATA",  64'(HWDATA),  mdv ? 64'(a_wd[mdo]) : 64'd0);
            chk("mdl HWSTRB",  64'(HWSTRB),  mdv ? 64'(a_strb[mdo]) : 64'd0);
            chk("mdl hmaster_data", 64'(hmaster_data), 64'(mdo));
            chk("mdl data_valid",   64'(data_valid),   64'(mdv));
        end
    end

    // Accepted beats per manager, observed on the shared bus.
    int acc_cnt [NM];
    always @(posedge HCLK) begin
        if (!HRESET && HREADY && HTRANS[1]) begin
            for (int i = 0; i < NM; i++) if (m_grant[i]) acc_cnt[i]++;
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic setm(input int i, input bit req, input logic [1:0] tr, input logic [31:0] ad,
                        input bit wr, input logic [2:0] bu, input logic [31:0] wd);
        a_req[i]   = req;
        a_trans[i] = tr;
        a_addr[i]  = ad;
        a_write[i] = wr;
        a_size[i]  = 3'd2;
        a_burst[i] = bu;
        a_wd[i]    = wd;
        a_strb[i]  = wr ? 4'hF : 4'h0;
    endtask

    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NSQ = 2'd2, SEQ = 2'd3;

    logic [1:0]  e_tr [7] = '{NSQ, SEQ, BUSY, SEQ, SEQ, SEQ, SEQ};
    logic [31:0] e_ad [7] = '{32'h300, 32'h304, 32'h308, 32'h308, 32'h30C, 32'h310, 32'h314};

    initial begin
        acc_cnt[0] = 0;
        acc_cnt[1] = 0;
        HRESET = 1'b1;
        HREADY = 1'b1;
        setm(0, 0, IDLE, 0, 0, 0, 0);
        setm(1, 0, IDLE, 0, 0, 0, 0);
        tick();
        tick();
        chk("reset m_grant", 64'(m_grant), 64'd0);
        chk("reset HTRANS", 64'(HTRANS), 64'd0);
        chk("reset data_valid", 64'(data_valid), 64'd0);
        chk("reset hmaster_data", 64'(hmaster_data), 64'd0);

        // Two SINGLE requesters alternate.
        HRESET = 1'b0;
        setm(0, 1, NSQ, 32'h10, 1, 3'd0, 32'hA0A0A0A0);
        setm(1, 1, NSQ, 32'h20, 0, 3'd0, 32'hB1B1B1B1);
        tick();
        chk("rr grant1", 64'(m_grant), 64'h1);
        chk("rr HADDR1", 64'(HADDR), 64'h10);
        chk("rr HTRANS1", 64'(HTRANS), 64'h2);
        chk("rr dvalid1", 64'(data_valid), 64'h0);
        tick();
        chk("rr grant2", 64'(m_grant), 64'h2);
        chk("rr hmaster2", 64'(hmaster_data), 64'h0);
        chk("rr HWDATA2", 64'(HWDATA), 64'hA0A0A0A0);
        chk("rr HADDR2", 64'(HADDR), 64'h20);
        tick();
        chk("rr grant3", 64'(m_grant), 64'h1);
        chk("rr hmaster3", 64'(hmaster_data), 64'h1);
        chk("rr HWDATA3", 64'(HWDATA), 64'hB1B1B1B1);
        tick();
        chk("rr grant4", 64'(m_grant), 64'h2);
        chk("rr hmaster4", 64'(hmaster_data), 64'h0);
        setm(0, 0, IDLE, 0, 0, 3'd0, 32'hA0A0A0A0);
        setm(1, 0, IDLE, 0, 0, 3'd0, 32'hB1B1B1B1);
        tick();
        chk("rr release grant", 64'(m_grant), 64'h0);

        // Idle bus.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle HTRANS", 64'(HTRANS), 64'h0);
            chk("idle HADDR", 64'(HADDR), 64'h0);
            chk("idle data_valid", 64'(data_valid), 64'h0);
        end

        // INCR4 from manager 0 while manager 1 waits.
        setm(0, 1, NSQ, 32'h100, 1, 3'd3, 0);
        setm(1, 1, NSQ, 32'h200, 0, 3'd0, 32'h22222222);
        tick();
        chk("incr4 grant", 64'(m_grant), 64'h1);
        chk("incr4 HADDR0", 64'(HADDR), 64'h100);
        chk("incr4 HBURST", 64'(HBURST), 64'h3);
        tick();
        setm(0, 1, SEQ, 32'h104, 1, 3'd3, 32'hD0000001);
        #1;
        chk("incr4 HADDR1", 64'(HADDR), 64'h104);
        chk("incr4 HWDATA1", 64'(HWDATA), 64'hD0000001);
        tick();
        setm(0, 1, SEQ, 32'h108, 1, 3'd3, 32'hD0000002);
        #1;
        chk("incr4 HADDR2", 64'(HADDR), 64'h108);
        chk("incr4 HWDATA2", 64'(HWDATA), 64'hD0000002);
        tick();
        setm(0, 1, SEQ, 32'h10C, 1, 3'd3, 32'hD0000003);
        #1;
        chk("incr4 grant3", 64'(m_grant), 64'h1);
        chk("incr4 HADDR3", 64'(HADDR), 64'h10C);
        chk("incr4 HWDATA3", 64'(HWDATA), 64'hD0000003);
        tick();
        setm(0, 0, IDLE, 0, 1, 3'd0, 32'hD0000004);
        #1;
        chk("incr4 handover grant", 64'(m_grant), 64'h2);
        chk("incr4 handover HADDR", 64'(HADDR), 64'h200);
        chk("incr4 handover hmaster", 64'(hmaster_data), 64'h0);
        chk("incr4 HWDATA4", 64'(HWDATA), 64'hD0000004);
        tick();
        chk("incr4 m1 hmaster", 64'(hmaster_data), 64'h1);
        setm(1, 0, IDLE, 0, 0, 3'd0, 32'h22222222);
        tick();
        chk("incr4 end grant", 64'(m_grant), 64'h0);

        // WRAP4 with a three-cycle wait state on beat 2.
        acc_cnt[0] = 0;
        setm(0, 1, NSQ, 32'h208, 1, 3'd2, 0);
        tick();
        chk("wrap4 grant", 64'(m_grant), 64'h1);
        tick();
        setm(0, 1, SEQ, 32'h20C, 1, 3'd2, 32'hE1);
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait grant", 64'(m_grant), 64'h1);
            chk("wait HADDR", 64'(HADDR), 64'h20C);
            chk("wait hmaster", 64'(hmaster_data), 64'h0);
            chk("wait data_valid", 64'(data_valid), 64'h1);
        end
        HREADY = 1'b1;
        tick();
        setm(0, 1, SEQ, 32'h200, 1, 3'd2, 32'hE2);
        tick();
        setm(0, 1, SEQ, 32'h204, 1, 3'd2, 32'hE3);
        tick();
        setm(0, 0, IDLE, 0, 1, 3'd2, 32'hE4);
        #1;
        chk("wrap4 last HWDATA", 64'(HWDATA), 64'hE4);
        tick();
        chk("wrap4 beats", 64'(acc_cnt[0]), 64'd4);
        chk("wrap4 end grant", 64'(m_grant), 64'h0);

        // Undefined-length INCR from manager 1 with one BUSY, then request drop.
        acc_cnt[1] = 0;
        setm(1, 1, NSQ, 32'h300, 0, 3'd1, 0);
        tick();
        for (int j = 0; j < 7; j++) begin
            setm(1, (j == 6) ? 1'b0 : 1'b1, e_tr[j], e_ad[j], 0, 3'd1, 0);
            #1;
            chk("incr hold grant", 64'(m_grant), 64'h2);
            tick();
        end
        setm(1, 0, IDLE, 0, 0, 3'd1, 0);
        #1;
        chk("incr release grant", 64'(m_grant), 64'h0);
        chk("incr release HTRANS", 64'(HTRANS), 64'h0);
        chk("incr last data_valid", 64'(data_valid), 64'h1);
        chk("incr last hmaster", 64'(hmaster_data), 64'h1);
        chk("incr beats", 64'(acc_cnt[1]), 64'd6);

        // Reset in the middle of an INCR8.
        setm(0, 1, NSQ, 32'h400, 1, 3'd5, 0);
        setm(1, 1, NSQ, 32'h500, 0, 3'd0, 0);
        tick();
        chk("incr8 grant", 64'(m_grant), 64'h1);
        tick();
        setm(0, 1, SEQ, 32'h404, 1, 3'd5, 32'hF1);
        tick();
        setm(0, 1, SEQ, 32'h408, 1, 3'd5, 32'hF2);
        HRESET = 1'b1;
        tick();
        chk("abort grant", 64'(m_grant), 64'h0);
        chk("abort HTRANS", 64'(HTRANS), 64'h0);
        chk("abort data_valid", 64'(data_valid), 64'h0);
        HRESET = 1'b0;
        setm(0, 1, NSQ, 32'h400, 1, 3'd5, 0);
        tick();
        chk("post-reset grant", 64'(m_grant), 64'h1);
        setm(0, 0, IDLE, 0, 0, 3'd0, 0);
        setm(1, 0, IDLE, 0, 0, 3'd0, 0);
        tick();
        chk("final grant", 64'(m_grant), 64'h0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ahb5_mgr_arbiter.md
# ahb5_mgr_arbiter

Round-robin arbiter that shares a single AHB5 subordinate port between NUM_MGR managers. It grants the bus per transfer or per burst and muxes the granted manager's address/control onto the shared bus. It also tracks the data-phase owner so write data and the owner index (for HRDATA/HRESP routing) stay aligned with the AHB pipeline. It sits between the manager agents/BFMs and the HSEL1 subordinate.

## Interface
- NUM_MGR, 2: number of managers (2..4).
- ADDR_WIDTH, 32: HADDR width.
- DATA_WIDTH, 32: HWDATA width.
- STRB_WIDTH, DATA_WIDTH/8: HWSTRB width.
- MW, max(1,$clog2(NUM_MGR)): manager index width.

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- m_req  in  NUM_MGR  per-manager bus request.
- m_haddr  in  NUM_MGR*ADDR_WIDTH  packed, manager i at slice i.
- m_htrans  in  NUM_MGR*2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- m_hwrite  in  NUM_MGR  1=write.
- m_hsize  in  NUM_MGR*3  transfer size.
- m_hburst  in  NUM_MGR*3  SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
- m_hwdata  in  NUM_MGR*DATA_WIDTH  write data (data phase).
- m_hwstrb  in  NUM_MGR*STRB_WIDTH  write strobes (data phase).
- HREADY  in  1  subordinate HREADYOUT; 1 = current phase completes.
- m_grant  out  NUM_MGR  one-hot registered grant (address-phase owner).
- HADDR, HWRITE, HSIZE, HBURST, HTRANS  out  ADDR_WIDTH/1/3/3/2  muxed address phase.
- HWDATA, HWSTRB  out  DATA_WIDTH/STRB_WIDTH  muxed data phase.
- hmaster_data  out  MW  data-phase owner index.
- data_valid  out  1  a NONSEQ/SEQ data phase is in progress.

## Operation
- Registers: addr_owner (one-hot, 0 = none), data_owner + data_valid, beats_left (5 bit), rr_last (index of last winner).
- Address mux: if addr_owner=0, HTRANS=IDLE and HADDR/HWRITE/HSIZE/HBURST=0. Otherwise forward the owner's slice combinationally.
- Data mux: HWDATA/HWSTRB are taken from the data_owner slice when data_valid=1, else 0.
- Beat accept: an edge with HREADY=1, owner present, owner HTRANS ∈ {NONSEQ, SEQ}.
  - NONSEQ loads beats_left = len-1 (SINGLE/INCR: 0; x4: 3; x8: 7; x16: 15).
  - SEQ decrements beats_left.
  - BUSY and IDLE do not change beats_left.
- Arbitration point: an edge with HREADY=1 and any of:
  - no owner;
  - owner drives IDLE;
  - accepted beat of a fixed-length burst or SINGLE leaves beats_left=0 after update;
  - owner HBURST=INCR and m_req[owner]=0.
- At an arbitration point, m_grant/addr_owner take the round-robin winner: first requester searching from rr_last+1 upward with wrap. The winner updates rr_last. No requester gives owner = none.
- A fixed burst is never interrupted; m_req drop mid-burst is ignored until the last beat is accepted.
- Data-phase tracking, on HREADY=1 edges only:
  - data_owner ← current owner index;
  - data_valid ← beat accepted this edge.
  - HREADY=0 holds both.
- Managers must not change address/control while HREADY=0; the arbiter does not check this.

## Timing
- Reset: m_grant=0, addr_owner=none, HTRANS=IDLE, HADDR/HWRITE/HSIZE/HBURST=0, HWDATA/HWSTRB=0, hmaster_data=0, data_valid=0, beats_left=0, rr_last=NUM_MGR-1 (manager 0 wins first). HRESET mid-burst aborts immediately; no completion beats.
- Grant latency: m_req rising at edge k with bus free and HREADY=1 gives m_grant at k+1. The manager's first NONSEQ appears on HADDR in the same cycle (combinational mux).
- Handover: last accepted beat at edge k moves the grant at edge k. The new owner's NONSEQ is in the address phase while the old owner's data phase completes; hmaster_data still shows the old owner.
- HREADY=0 at any edge freezes grant, beats_left, data_owner and data_valid.
- Simultaneous requests are resolved strictly by round-robin.

## Test plan
- Reset then m_req=2'b11, both SINGLE, HREADY=1 → grant sequence 01,10,01,10; each manager gets one HTRANS=NONSEQ per tenure; hmaster_data lags m_grant by one cycle.
- Manager 0 INCR4 writes at 0x100, manager 1 requesting throughout → grant stays 01 for 4 accepted beats (HADDR 0x100,0x104,0x108,0x10C), then 10; HWDATA shows M0 data for beats 1-4 one cycle after each address.
- HREADY=0 for 3 cycles during beat 2 of WRAP4 → HADDR, m_grant, beats_left, data_owner all held; burst completes with exactly 4 accepted beats.
- Manager 1 INCR undefined burst, 6 beats with one BUSY, then m_req drop → grant held 7 cycles; released on the edge m_req=0 with HREADY=1; HTRANS=IDLE when no other requester.
- Assert HRESET after 2 beats of INCR8 → next cycle m_grant=0, HTRANS=IDLE, data_valid=0; after release, manager 0 is granted first.
- No requests for 10 cycles → HTRANS=IDLE, HADDR=0, data_valid=0 throughout.
